// File: rtl/stuffed_stream_uart_tx.sv
// Buffers the stuffer's byte stream in a FIFO and sends it as 8N1 UART.
// Flags dropped bytes and pulses frame_end once a delimited frame has fully left the wire.
module stuffed_stream_uart_tx #(
    parameter logic [6:0] clock_divider   = 7'd6,
    parameter int         fifo_depth_log2 = 9
) (
    input  logic                     clock,
    input  logic                     nreset,
    input  logic                     data_in_valid,
    input  logic [7:0]               data_in,
    input  logic                     vsync_in,
    output logic                     uart_tx,
    output logic                     busy,
    output logic [fifo_depth_log2:0] fifo_count,
    output logic                     overflow,
    output logic                     frame_end
);

    localparam int DEPTH = 1 << fifo_depth_log2;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                     state;
    logic [7:0]                 mem [DEPTH];
    logic [fifo_depth_log2-1:0] wr_ptr;
    logic [fifo_depth_log2-1:0] rd_ptr;
    logic [6:0]                 baud_cnt;
    logic [2:0]                 bit_idx;
    logic [7:0]                 shift;
    logic                       vsync_q;
    logic                       pending;

    logic baud_last, fifo_empty, fifo_full, pop, push, vsync_fall, fire;

    assign baud_last  = (baud_cnt == clock_divider - 7'd1);
    assign fifo_empty = (fifo_count == '0);
    // count never exceeds DEPTH, so its MSB alone means full
    assign fifo_full  = fifo_count[fifo_depth_log2];
    assign pop        = !fifo_empty && ((state == IDLE) || (state == STOP && baud_last));
    assign push       = data_in_valid && (!fifo_full || pop);
    assign vsync_fall = vsync_q && !vsync_in;
    assign fire       = pending && (state == IDLE) && fifo_empty;

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (data_in_valid && !push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            uart_tx   <= 1'b1;
            busy      <= 1'b0;
            frame_end <= 1'b0;
            vsync_q   <= 1'b0;
            pending   <= 1'b0;
        end else begin
            // line level follows the state one cycle later, so every bit keeps its full width
            uart_tx   <= (state == START) ? 1'b0 : (state == DATA) ? shift[bit_idx] : 1'b1;
            busy      <= (state != IDLE) || !fifo_empty;
            frame_end <= fire;
            pending   <= vsync_fall || (pending && !fire);
            vsync_q   <= vsync_in;
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift    <= mem[rd_ptr];
                        baud_cnt <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 7'd1;
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) state <= STOP;
                        else                 bit_idx <= bit_idx + 3'd1;
                    end else begin
                        baud_cnt <= baud_cnt + 7'd1;
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 7'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stuffed_stream_uart_tx.sv
// Bench for stuffed_stream_uart_tx: timeline model of FIFO + UART checked every cycle,
// a line decoder, and directed/random stimulus on a 4-deep instance.
module tb_stuffed_stream_uart_tx;

    localparam int D     = 6;
    localparam int LOG2  = 2;
    localparam int DEPTH = 1 << LOG2;

    logic            clock = 1'b0;
    logic            nreset = 1'b0;
    logic            data_in_valid = 1'b0;
    logic [7:0]      data_in = 8'h00;
    logic            vsync_in = 1'b0;
    logic            uart_tx, busy, overflow, frame_end;
    logic [LOG2:0]   fifo_count;

    stuffed_stream_uart_tx #(.clock_divider(7'(D)), .fifo_depth_log2(LOG2)) dut (
        .clock(clock), .nreset(nreset), .data_in_valid(data_in_valid), .data_in(data_in),
        .vsync_in(vsync_in), .uart_tx(uart_tx), .busy(busy), .fifo_count(fifo_count),
        .overflow(overflow), .frame_end(frame_end)
    );

    always #5 clock = ~clock;

    int tests = 0, fails = 0;
    int cyc = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Model: bytes waiting, byte on the wire with its elapsed time, frame flag.
    logic [7:0] q[$];
    logic [7:0] exp_tx[$];
    logic [7:0] m_cur = 8'h00;
    int         m_active = 0, m_t = 0;
    logic       m_ovf = 1'b0, m_pend = 1'b0, m_vprev = 1'b0;
    logic       e_tx = 1'b1, e_busy = 1'b0, e_fe = 1'b0;

    initial forever begin
        @(posedge clock or negedge nreset);
        if (!nreset) begin
            q.delete(); exp_tx.delete();
            m_active = 0; m_t = 0; m_ovf = 1'b0; m_pend = 1'b0; m_vprev = 1'b0;
            e_tx = 1'b1; e_busy = 1'b0; e_fe = 1'b0;
        end else begin
            int cnt, b;
            logic end_byte, pop, fire;
            cyc++;
            cnt      = q.size();
            end_byte = (m_active != 0) && (m_t == 10*D - 1);
            pop      = (cnt > 0) && ((m_active == 0) || end_byte);
            if (m_active == 0) e_tx = 1'b1;
            else begin
                b = m_t / D;
                e_tx = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : m_cur[b-1];
            end
            e_busy  = (m_active != 0) || (cnt > 0);
            fire    = m_pend && (m_active == 0) && (cnt == 0);
            e_fe    = fire;
            m_pend  = (m_vprev && !vsync_in) || (m_pend && !fire);
            m_vprev = vsync_in;
            if (pop) begin
                m_cur = q.pop_front();
                exp_tx.push_back(m_cur);
                m_active = 1; m_t = 0;
            end else if (end_byte) m_active = 0;
            else if (m_active != 0) m_t++;
            if (data_in_valid && (cnt < DEPTH || pop)) q.push_back(data_in);
            else if (data_in_valid) m_ovf = 1'b1;
        end
    end

    int peak = 0, fe_count = 0, fe_cyc = -1;

    initial forever begin
        @(negedge clock);
        if (chk_en) begin
            chk("uart_tx", {31'b0, uart_tx}, {31'b0, e_tx});
            chk("busy", {31'b0, busy}, {31'b0, e_busy});
            chk("frame_end", {31'b0, frame_end}, {31'b0, e_fe});
            chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
            chk("fifo_count", 32'(fifo_count), 32'(q.size()));
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            if (frame_end) begin fe_count++; fe_cyc = cyc; end
        end
    end

    // Line decoder: mid-bit sampling, compared against bytes the model popped.
    logic [7:0] rx_log[$];
    int         rx_start_log[$];
    initial begin
        logic       rx_on;
        int         rx_t, rx_st;
        logic [7:0] rx_b;
        rx_on = 1'b0; rx_t = 0; rx_st = 0; rx_b = 8'h00;
        forever begin
            @(negedge clock);
            if (!nreset) rx_on = 1'b0;
            else if (!rx_on) begin
                if (chk_en && uart_tx == 1'b0) begin rx_on = 1'b1; rx_t = 0; rx_st = cyc; end
            end else begin
                rx_t++;
                if (rx_t >= D + D/2 && rx_t < 9*D && ((rx_t - D/2) % D) == 0)
                    rx_b[(rx_t - D/2)/D - 1] = uart_tx;
                if (rx_t == 9*D + D/2) begin
                    chk("stop_bit", {31'b0, uart_tx}, 32'd1);
                    if (exp_tx.size() == 0) chk("rx_unexpected", {24'b0, rx_b}, 32'hFFFF_FFFF);
                    else chk("rx_byte", {24'b0, rx_b}, {24'b0, exp_tx.pop_front()});
                    rx_log.push_back(rx_b);
                    rx_start_log.push_back(rx_st);
                    rx_on = 1'b0;
                end
            end
        end
    end

    task automatic drain(input string nm);
        int k = 0;
        repeat (2) @(negedge clock);
        while ((busy || fifo_count != 0) && k < 3000) begin @(negedge clock); k++; end
        tests++;
        if (k >= 3000) begin fails++; $display("FAIL %s_drain: still busy after %0d cycles, required idle", nm, k); end
        repeat (3) @(negedge clock);
    endtask

    task automatic strobe(input logic [7:0] b);
        data_in_valid = 1'b1; data_in = b;
        @(negedge clock);
        data_in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock); nreset = 1'b0;
        @(negedge clock); nreset = 1'b1;
    endtask

    initial begin
        int e0;
        logic [9:0] pat;
        logic [7:0] burst [4];
        burst[0] = 8'hFF; burst[1] = 8'hD9; burst[2] = 8'h00; burst[3] = 8'h55;

        repeat (3) @(negedge clock);
        chk("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_overflow", {31'b0, overflow}, 32'd0);
        chk("rst_frame_end", {31'b0, frame_end}, 32'd0);
        nreset = 1'b1; chk_en = 1'b1;
        @(negedge clock);

        // single byte A5, literal waveform
        e0 = cyc + 1;
        strobe(8'hA5);
        chk("a5_count_after_write", 32'(fifo_count), 32'd1);
        @(negedge clock);
        chk("a5_line_before_start", {31'b0, uart_tx}, 32'd1);
        pat = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 10*D; i++) begin
            @(negedge clock);
            chk("a5_wire", {31'b0, uart_tx}, {31'b0, pat[i/D]});
        end
        @(negedge clock);
        chk("a5_busy_fall", {31'b0, busy}, 32'd0);
        chk("a5_count_end", 32'(fifo_count), 32'd0);
        chk("a5_rx", {24'b0, rx_log[rx_log.size()-1]}, 32'h0A5);
        chk("a5_start_cycle", 32'(rx_start_log[rx_start_log.size()-1]), 32'(e0 + 2));

        // burst of four, back-to-back on the wire
        repeat (3) @(negedge clock);
        rx_log.delete(); rx_start_log.delete(); peak = 0;
        e0 = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            data_in_valid = 1'b1; data_in = burst[i];
            @(negedge clock);
        end
        data_in_valid = 1'b0;
        drain("burst");
        chk("burst_peak", 32'(peak), 32'd3);
        chk("burst_nbytes", 32'(rx_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < rx_log.size(); i++) chk("burst_byte", {24'b0, rx_log[i]}, {24'b0, burst[i]});
        if (rx_start_log.size() == 4) begin
            chk("burst_first_start", 32'(rx_start_log[0]), 32'(e0 + 2));
            chk("burst_span", 32'(rx_start_log[3] + 10*D - rx_start_log[0]), 32'd240);
        end

        // eight strobes into a 4-deep FIFO
        rx_log.delete();
        for (int i = 0; i < 8; i++) begin
            data_in_valid = 1'b1; data_in = 8'(8'h10 + i);
            @(negedge clock);
        end
        data_in_valid = 1'b0;
        chk("ovf_set", {31'b0, overflow}, 32'd1);
        drain("ovf");
        chk("ovf_sticky", {31'b0, overflow}, 32'd1);
        chk("ovf_nbytes", 32'(rx_log.size()), 32'd5);
        for (int i = 0; i < 5 && i < rx_log.size(); i++) chk("ovf_byte", {24'b0, rx_log[i]}, 32'(8'h10 + i));

        // write on the same cycle as a pop while full
        do_reset();
        chk("full_ovf_cleared", {31'b0, overflow}, 32'd0);
        e0 = cyc + 1;
        for (int i = 0; i < 5; i++) begin
            data_in_valid = 1'b1; data_in = 8'(8'h20 + i);
            @(negedge clock);
        end
        data_in_valid = 1'b0;
        while (cyc < e0 + 60) @(negedge clock);
        chk("full_before", 32'(fifo_count), 32'd4);
        strobe(8'hC3);
        chk("full_pop_count", 32'(fifo_count), 32'd4);
        chk("full_pop_ovf", {31'b0, overflow}, 32'd0);
        rx_log.delete();
        drain("full");
        chk("full_last_byte", {24'b0, rx_log[rx_log.size()-1]}, 32'h0C3);

        // frame end after delimiter drains; second fall while pending
        rx_log.delete(); rx_start_log.delete(); fe_count = 0; fe_cyc = -1;
        vsync_in = 1'b1;
        strobe(8'hFF); strobe(8'hD9); strobe(8'h42);
        repeat (7) @(negedge clock);
        vsync_in = 1'b0;
        repeat (30) @(negedge clock);
        vsync_in = 1'b1;
        repeat (5) @(negedge clock);
        vsync_in = 1'b0;
        drain("frame");
        chk("frame_pulses", 32'(fe_count), 32'd1);
        if (rx_start_log.size() == 3) chk("frame_pulse_cycle", 32'(fe_cyc), 32'(rx_start_log[2] + 10*D));
        else chk("frame_nbytes", 32'(rx_start_log.size()), 32'd3);

        // async reset mid-DATA with overflow set
        rx_log.delete();
        for (int i = 0; i < 6; i++) begin
            data_in_valid = 1'b1; data_in = 8'(8'h96 + i);
            @(negedge clock);
        end
        data_in_valid = 1'b0;
        chk("rst_mid_ovf_pre", {31'b0, overflow}, 32'd1);
        repeat (20) @(negedge clock);
        #2 nreset = 1'b0;
        #1;
        chk("rst_mid_uart_tx", {31'b0, uart_tx}, 32'd1);
        chk("rst_mid_count", 32'(fifo_count), 32'd0);
        chk("rst_mid_ovf", {31'b0, overflow}, 32'd0);
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        @(negedge clock);
        @(negedge clock); nreset = 1'b1;
        @(negedge clock);
        strobe(8'h3C);
        drain("rst_mid");
        chk("rst_mid_nbytes", 32'(rx_log.size()), 32'd1);
        chk("rst_mid_byte", {24'b0, rx_log[rx_log.size()-1]}, 32'h03C);

        // random traffic with random vsync, checked by the model every cycle
        for (int i = 0; i < 1500; i++) begin
            data_in_valid = ($urandom_range(0, 99) < ((i < 750) ? 2 : 10));
            data_in = 8'($urandom);
            if ($urandom_range(0, 49) == 0) vsync_in = ~vsync_in;
            @(negedge clock);
        end
        data_in_valid = 1'b0;
        vsync_in = 1'b0;
        drain("random");
        chk("random_all_sent", 32'(exp_tx.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stuffed_stream_uart_tx.md
Name: stuffed_stream_uart_tx

Overview:
- Downstream consumer of the frame-end stuffer's byte stream (data_out_valid / data_out / vsync_out).
- Buffers bytes in an on-chip FIFO and serialises them as 8N1 UART on a single pin. The pin goes to the host link (uart_tx_config_copi).
- The stuffer has no backpressure, so this block absorbs bursts, flags any drops, and signals when a complete frame (including its delimiter) has left the wire.

Parameters:
- clock_divider, 7'd6, clock cycles per UART bit (12 MHz / 6 = 2 Mbaud). Legal range 2..127.
- fifo_depth_log2, 9, FIFO holds 2**fifo_depth_log2 bytes (default 512).

Ports:
- clock  input  1  system clock (osc_12m); all logic on the rising edge.
- nreset  input  1  asynchronous, active-low reset.
- data_in_valid  input  1  byte strobe from the stuffer; one byte per asserted cycle.
- data_in  input  8  byte from the stuffer.
- vsync_in  input  1  stuffer vsync_out, active high.
- uart_tx  output  1  serial line; idle high.
- busy  output  1  high while the FIFO is non-empty or the transmitter is not IDLE.
- fifo_count  output  fifo_depth_log2+1  bytes currently stored.
- overflow  output  1  sticky: a byte was dropped because the FIFO was full.
- frame_end  output  1  one-cycle pulse when a frame's last byte has finished transmitting.

Behaviour:
- Reset (nreset low, asynchronous): uart_tx=1, busy=0, fifo_count=0, overflow=0, frame_end=0. FSM goes to IDLE; FIFO pointers, bit counter and baud counter clear; frame-pending flag clears. Reset mid-byte abandons the byte; the line goes high immediately.
- FIFO write: on a cycle with data_in_valid=1, the byte is stored if fifo_count < 2**fifo_depth_log2. Otherwise it is dropped and overflow<=1, held until reset.
- FIFO pop: occurs only on a load event (see FSM). If a pop and a write coincide while full, the write is accepted and fifo_count is unchanged.
- Counter update: fifo_count updates one cycle after the write/pop edge and is exact every cycle, with +1/-1/0 applied for write/pop/both.
- Pointers wrap modulo depth.
- FSM states:
  - IDLE: uart_tx=1. If fifo_count!=0, pop head into the shift register, baud counter=0, go START.
  - START: uart_tx=0 for clock_divider cycles, then DATA with bit index 0.
  - DATA: uart_tx=shift[bit index], LSB first, each bit for clock_divider cycles. After bit 7, go STOP.
  - STOP: uart_tx=1 for clock_divider cycles. On the final STOP cycle, if fifo_count!=0, pop and go directly to START (back-to-back, no idle gap); else go IDLE.
- uart_tx is registered. Start bit begins 2 clocks after the edge sampling the first data_in_valid into an empty, idle block.
- Each byte occupies exactly 10*clock_divider cycles; consecutive bytes are contiguous while the FIFO stays non-empty.
- Frame tracking:
  - Register vsync_in.
  - A falling edge (prev=1, cur=0) sets frame-pending.
  - When frame-pending=1, the FSM is IDLE and fifo_count=0, assert frame_end for one cycle and clear pending.
  - Further falling edges while pending do not produce extra pulses.
  - A falling edge on the same cycle that pending clears re-sets pending.
- No combinational path from inputs to outputs.

Test Plan:
- Single byte 8'hA5 into an idle block, clock_divider=6 -> uart_tx low 2 clocks after strobe for 6 cycles, then 1,0,1,0,0,1,0,1 (6 cycles each), then high 6 cycles. busy falls the cycle after the stop bit ends; fifo_count back to 0.
- Burst of 4 bytes {8'hFF,8'hD9,8'h00,8'h55} on consecutive cycles -> fifo_count peaks at 3 (first byte popped immediately). Four back-to-back frames totalling exactly 240 cycles with no idle gap; decoded bytes match in order.
- Depth 4 (fifo_depth_log2=2), 8 consecutive strobes -> first 5 accepted (1 in shifter + 4 stored), remaining 3 dropped. overflow=1 and stays high after the drain; transmitted sequence is bytes 0..4.
- Full FIFO with a pop on the same cycle as a write -> write accepted, fifo_count unchanged, no overflow.
- vsync_in high 10 cycles then low, with 3 bytes queued (delimiter FF D9 plus one) -> exactly one frame_end pulse, 1 cycle after the final stop bit completes. A second vsync fall during the drain produces no second pulse.
- nreset pulsed low mid-DATA of a byte -> uart_tx=1 asynchronously, fifo_count=0, overflow=0. The next written byte transmits cleanly with correct framing.
